// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES-128 decrypt round-key sequencer.
package aes_dec_pkg;

  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned KEY_W     = 128;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned IDX_W     = 4;

  localparam logic [ADDR_W-1:0] ADDR_IDLE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    LOAD
  } state_t;

endpackage

// File: rtl/dec_rkey_ctrl_if.sv
// Key-stream, round-key broadcast and block-admission signals of the sequencer.
interface dec_rkey_ctrl_if;
  import aes_dec_pkg::*;

  logic              key_start;
  logic              key_vld;
  logic              key_rdy;
  logic [KEY_W-1:0]  key_data;
  logic [KEY_W-1:0]  rkey;
  logic [ADDR_W-1:0] addr;
  logic              din_vld;
  logic              din_rdy;
  logic              dout_vld;
  logic              keys_loaded;
  logic              busy;

  modport master (
    output key_start, key_vld, key_data, din_vld,
    input  key_rdy, rkey, addr, din_rdy, dout_vld, keys_loaded, busy
  );

  modport slave (
    input  key_start, key_vld, key_data, din_vld,
    output key_rdy, rkey, addr, din_rdy, dout_vld, keys_loaded, busy
  );

endinterface

// File: rtl/dec_inflight_tracker.sv
// Blocks-in-flight tracker: a PIPE_LAT-deep shift of accepted handshakes.
module dec_inflight_tracker #(
  parameter int unsigned PIPE_LAT = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  output logic dout_vld,
  output logic in_flight_empty
);

  localparam int unsigned STG_W = PIPE_LAT - 1;

  // dout_vld is the last bit of the shift; a block there has already left the pipe.
  logic [STG_W-1:0] stg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stg      <= '0;
      dout_vld <= 1'b0;
    end else begin
      stg      <= {stg[STG_W-2:0], accept};
      dout_vld <= stg[STG_W-1];
    end
  end

  assign in_flight_empty = (stg == '0);

endmodule

// File: rtl/dec_rkey_ctrl.sv
// Round-key loader and block-admission sequencer for the AES-128 decrypt pipeline.
module dec_rkey_ctrl
  import aes_dec_pkg::*;
#(
  parameter int unsigned NR       = NR_AES128,
  parameter int unsigned PIPE_LAT = 20
) (
  input  logic             clk,
  input  logic             rst,
  dec_rkey_ctrl_if.slave   bus
);

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [KEY_W-1:0]  rkey_q, rkey_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              key_rdy_q, keys_loaded_q, busy_q;
  logic              din_rdy, accept, in_flight_empty, dout_vld;

  // A key_start in RUN closes admission in the same cycle.
  assign din_rdy = (state == RUN) && !bus.key_start;
  assign accept  = bus.din_vld && din_rdy;

  dec_inflight_tracker #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tracker (
    .clk             (clk),
    .rst             (rst),
    .accept          (accept),
    .dout_vld        (dout_vld),
    .in_flight_empty (in_flight_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= '0;
      rkey_q        <= '0;
      addr_q        <= ADDR_IDLE;
      key_rdy_q     <= 1'b0;
      keys_loaded_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      rkey_q        <= rkey_n;
      addr_q        <= addr_n;
      key_rdy_q     <= (state_n == LOAD);
      keys_loaded_q <= (state_n == RUN) || (state_n == DRAIN);
      busy_q        <= (state_n == DRAIN) || (state_n == LOAD);
    end
  end

  // Encryption key k is written to decrypt stage NR-k.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    rkey_n  = rkey_q;
    addr_n  = ADDR_IDLE;
    case (state)
      IDLE: begin
        if (bus.key_start) begin
          state_n = LOAD;
          idx_n   = '0;
        end
      end
      RUN: begin
        if (bus.key_start) state_n = DRAIN;
      end
      DRAIN: begin
        if (in_flight_empty) begin
          state_n = LOAD;
          idx_n   = '0;
        end
      end
      LOAD: begin
        if (bus.key_start) begin
          idx_n = '0;
        end else if (bus.key_vld) begin
          rkey_n = bus.key_data;
          addr_n = ADDR_W'(NR) - ADDR_W'(idx);
          if (idx == IDX_W'(NR)) begin
            idx_n   = '0;
            state_n = RUN;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.key_rdy     = key_rdy_q;
  assign bus.rkey        = rkey_q;
  assign bus.addr        = addr_q;
  assign bus.din_rdy     = din_rdy;
  assign bus.dout_vld    = dout_vld;
  assign bus.keys_loaded = keys_loaded_q;
  assign bus.busy        = busy_q;

endmodule
